// File: rtl/i2c_cmd_sequencer.sv
// Command front-end for i2c_master: queues register read/write commands, issues them
// one at a time on the master request interface and returns one response per command.
module i2c_cmd_sequencer #(
  parameter int unsigned ADDR_BYTES     = 1,
  parameter int unsigned DATA_BYTES     = 2,
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_rw,
  input  logic [6:0]                    cmd_chip_addr,
  input  logic [8*ADDR_BYTES-1:0]       cmd_reg_addr,
  input  logic [8*DATA_BYTES-1:0]       cmd_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_rw,
  output logic [8*DATA_BYTES-1:0]       rsp_data,
  output logic [3:0]                    rsp_status,
  output logic                          rsp_timeout,
  output logic [$clog2(CMD_DEPTH):0]    fifo_level,
  output logic                          idle,
  output logic [6:0]                    m_chip_addr,
  output logic [8*ADDR_BYTES-1:0]       m_reg_addr,
  output logic [8*DATA_BYTES-1:0]       m_data_in,
  output logic                          m_write_en,
  output logic                          m_read_en,
  input  logic                          m_busy,
  input  logic [3:0]                    m_status,
  input  logic [8*DATA_BYTES-1:0]       m_data_out
);

  localparam int unsigned AW = 8 * ADDR_BYTES;
  localparam int unsigned DW = 8 * DATA_BYTES;
  localparam int unsigned PW = $clog2(CMD_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned CW = 1 + 7 + AW + DW;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_WAIT_END,
    S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [CW-1:0]   mem_q [CMD_DEPTH];
  logic [6:0]      m_chip_q, m_chip_d;
  logic [AW-1:0]   m_reg_q, m_reg_d;
  logic [DW-1:0]   m_data_q, m_data_d;
  logic            m_wr_en_q, m_wr_en_d;
  logic            m_rd_en_q, m_rd_en_d;
  logic            cur_rw_q, cur_rw_d;
  logic [15:0]     tmo_q, tmo_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_rw_q, rsp_rw_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic [3:0]      rsp_status_q, rsp_status_d;
  logic            rsp_timeout_q, rsp_timeout_d;
  logic            idle_q, idle_d;

  logic            full;
  logic            push;
  logic            pop;
  logic [CW-1:0]   head;
  logic            head_rw;
  logic [6:0]      head_chip;
  logic [AW-1:0]   head_reg;
  logic [DW-1:0]   head_data;

  // cmd_ready comes from the registered level only, so a pop never frees a slot early.
  assign full      = (level_q == LW'(CMD_DEPTH));
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;

  assign head      = mem_q[rd_ptr_q];
  assign head_rw   = head[CW-1];
  assign head_chip = head[CW-2 -: 7];
  assign head_reg  = head[DW +: AW];
  assign head_data = head[DW-1:0];

  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    m_chip_d      = m_chip_q;
    m_reg_d       = m_reg_q;
    m_data_d      = m_data_q;
    m_wr_en_d     = 1'b0;
    m_rd_en_d     = 1'b0;
    cur_rw_d      = cur_rw_q;
    tmo_d         = tmo_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rw_d      = rsp_rw_q;
    rsp_data_d    = rsp_data_q;
    rsp_status_d  = rsp_status_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      S_IDLE: begin
        if ((level_q != '0) && !rsp_valid_q && !m_busy) begin
          pop       = 1'b1;
          m_chip_d  = head_chip;
          m_reg_d   = head_reg;
          m_data_d  = head_data;
          cur_rw_d  = head_rw;
          m_rd_en_d = head_rw;
          m_wr_en_d = !head_rw;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (tmo_q == TMO_LAST) begin
          rsp_valid_d   = 1'b1;
          rsp_rw_d      = cur_rw_q;
          rsp_data_d    = '0;
          rsp_status_d  = m_status;
          rsp_timeout_d = 1'b1;
          state_d       = S_RESP;
        end else begin
          tmo_d = tmo_q + 16'd1;
          if (m_busy) state_d = S_WAIT_END;
        end
      end
      S_WAIT_END: begin
        // A completion seen in the same cycle as the deadline wins over the timeout.
        if (!m_busy) begin
          rsp_valid_d   = 1'b1;
          rsp_rw_d      = cur_rw_q;
          rsp_data_d    = cur_rw_q ? m_data_out : '0;
          rsp_status_d  = m_status;
          rsp_timeout_d = 1'b0;
          state_d       = S_RESP;
        end else if (tmo_q == TMO_LAST) begin
          rsp_valid_d   = 1'b1;
          rsp_rw_d      = cur_rw_q;
          rsp_data_d    = '0;
          rsp_status_d  = m_status;
          rsp_timeout_d = 1'b1;
          state_d       = S_RESP;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + (push ? PW'(1) : '0);
    rd_ptr_d = rd_ptr_q + (pop ? PW'(1) : '0);
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    idle_d = (level_d == '0) && (state_d == S_IDLE) && !rsp_valid_d;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_rw, cmd_chip_addr, cmd_reg_addr, cmd_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      m_chip_q      <= '0;
      m_reg_q       <= '0;
      m_data_q      <= '0;
      m_wr_en_q     <= 1'b0;
      m_rd_en_q     <= 1'b0;
      cur_rw_q      <= 1'b0;
      tmo_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rw_q      <= 1'b0;
      rsp_data_q    <= '0;
      rsp_status_q  <= '0;
      rsp_timeout_q <= 1'b0;
      idle_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      m_chip_q      <= m_chip_d;
      m_reg_q       <= m_reg_d;
      m_data_q      <= m_data_d;
      m_wr_en_q     <= m_wr_en_d;
      m_rd_en_q     <= m_rd_en_d;
      cur_rw_q      <= cur_rw_d;
      tmo_q         <= tmo_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rw_q      <= rsp_rw_d;
      rsp_data_q    <= rsp_data_d;
      rsp_status_q  <= rsp_status_d;
      rsp_timeout_q <= rsp_timeout_d;
      idle_q        <= idle_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rw      = rsp_rw_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_status  = rsp_status_q;
  assign rsp_timeout = rsp_timeout_q;
  assign fifo_level  = level_q;
  assign idle        = idle_q;
  assign m_chip_addr = m_chip_q;
  assign m_reg_addr  = m_reg_q;
  assign m_data_in   = m_data_q;
  assign m_write_en  = m_wr_en_q;
  assign m_read_en   = m_rd_en_q;

endmodule

// File: doc/i2c_cmd_sequencer.md
Name: i2c_cmd_sequencer

Overview:
Command front-end sitting directly upstream of i2c_master. Buffers register read/write commands in a small FIFO and issues them one at a time on the master's write_en/read_en request interface. Waits for each transaction to complete, then returns one response per command (read data, master status, timeout flag). Lets a host queue a burst of register accesses without polling master busy.

Parameters:
ADDR_BYTES, 1, register address width in bytes; must match i2c_master.
DATA_BYTES, 2, data width in bytes; must match i2c_master.
CMD_DEPTH, 4, command FIFO depth; power of two, >= 2.
TIMEOUT_CYCLES, 65535, clk cycles from request issue to forced abort; 16-bit counter.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  FIFO can accept; equals !full.
cmd_rw  in  1  1 = read, 0 = write.
cmd_chip_addr  in  7  target 7-bit chip address.
cmd_reg_addr  in  8*ADDR_BYTES  target register address.
cmd_data  in  8*DATA_BYTES  write data; ignored for reads.
rsp_valid  out  1  response available; held until accepted.
rsp_ready  in  1  response consumer ready.
rsp_rw  out  1  cmd_rw of the completed command.
rsp_data  out  8*DATA_BYTES  read data; 0 for writes and timeouts.
rsp_status  out  4  master status sampled at completion.
rsp_timeout  out  1  transaction aborted by timeout.
fifo_level  out  clog2(CMD_DEPTH)+1  queued command count.
idle  out  1  FIFO empty, FSM in IDLE, no response pending.
m_chip_addr  out  7  to master chip_addr.
m_reg_addr  out  8*ADDR_BYTES  to master reg_addr.
m_data_in  out  8*DATA_BYTES  to master data_in.
m_write_en  out  1  one-cycle write request.
m_read_en  out  1  one-cycle read request.
m_busy  in  1  master busy.
m_status  in  4  master status.
m_data_out  in  8*DATA_BYTES  master read data.

Behaviour:
- Reset: FIFO emptied, fifo_level=0, cmd_ready=1, rsp_valid=0, rsp_* = 0, m_* = 0, m_write_en=m_read_en=0, idle=1, FSM=IDLE, timeout counter=0.
- Push on cmd_valid&&cmd_ready. cmd_ready derives from full only: when full, a pop in the same cycle does not raise cmd_ready that cycle. Push into non-full FIFO while popping: level unchanged.
- FSM states: IDLE, ISSUE, WAIT_START, WAIT_END, RESP.
- IDLE -> ISSUE when FIFO non-empty && !rsp_valid && !m_busy. Head is popped on this transition. m_chip_addr, m_reg_addr and m_data_in are loaded from the head and held until the next pop.
- ISSUE: exactly one cycle; m_read_en=cmd_rw or m_write_en=!cmd_rw; timeout counter cleared. -> WAIT_START.
- WAIT_START: wait for m_busy=1, then -> WAIT_END.
- WAIT_END: on m_busy=0, capture rsp_data=m_data_out (reads; 0 for writes), rsp_status=m_status, rsp_timeout=0. Assert rsp_valid next cycle. -> RESP.
- Timeout: counter increments each cycle in WAIT_START/WAIT_END. At TIMEOUT_CYCLES: rsp_timeout=1, rsp_data=0, rsp_status=m_status. -> RESP.
- After a timeout, IDLE still waits for m_busy=0 before issuing.
- RESP: rsp_valid held with stable payload until rsp_ready; on handshake -> IDLE.
- Latency: push at cycle N into an empty, idle block -> request pulse at cycle N+2.
- Ordering: strictly in order, one outstanding transaction, one response per command.
- Reset mid-transaction: immediate return to reset state. Queued commands and the pending response are discarded; no further request pulses.
- idle is registered, consistent with FIFO/FSM state of the same cycle.

Test Plan:
- Write chip 0x0F reg 0x0A data 16'h1234 against i2c_master+i2c_slave -> single m_write_en pulse; slave receives 16'h1234 at reg 0x0A; one response with rsp_rw=0, rsp_data=0, rsp_timeout=0.
- Queue reads of regs 0x00,0x0A,0x10,0x1A with slave holding A1A1/B2B2/C3C3/D4D4 -> four in-order responses with exactly those values; fifo_level 4->0; m_read_en never asserted while m_busy=1.
- Push 5 commands back-to-back, CMD_DEPTH=4, master stalled -> cmd_ready low after the 4th push; 5th accepted only after the first pop.
- Hold rsp_ready=0 after the first completion -> rsp_valid and payload stable; no second request issued until rsp_ready=1.
- Master stub holds m_busy=1, TIMEOUT_CYCLES=100 -> response exactly 100 cycles after WAIT_START entry with rsp_timeout=1, rsp_data=0; next command waits for m_busy release.
- Assert reset for one cycle during WAIT_END with 2 queued commands -> next cycle idle=1, fifo_level=0, rsp_valid=0; no further m_*_en pulses.
